// File: rtl/armleosoc_axi_read_arbiter.sv
// armleosoc_axi_read_arbiter: round-robin arbiter sharing one AXI4 read channel among N hosts
module armleosoc_axi_read_arbiter #(
  parameter int OPT_NUMBER_OF_HOSTS = 2,
  parameter int ADDR_WIDTH = 34,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [OPT_NUMBER_OF_HOSTS-1:0]             host_arvalid,
  output logic [OPT_NUMBER_OF_HOSTS-1:0]             host_arready,
  input  logic [OPT_NUMBER_OF_HOSTS*ADDR_WIDTH-1:0]  host_araddr,
  input  logic [OPT_NUMBER_OF_HOSTS*8-1:0]           host_arlen,
  output logic [OPT_NUMBER_OF_HOSTS-1:0]             host_rvalid,
  input  logic [OPT_NUMBER_OF_HOSTS-1:0]             host_rready,
  output logic [DATA_WIDTH-1:0]                      host_rdata,
  output logic [1:0]                                 host_rresp,
  output logic                                       host_rlast,
  output logic                                       m_arvalid,
  input  logic                                       m_arready,
  output logic [ADDR_WIDTH-1:0]                      m_araddr,
  output logic [7:0]                                 m_arlen,
  input  logic                                       m_rvalid,
  output logic                                       m_rready,
  input  logic [DATA_WIDTH-1:0]                      m_rdata,
  input  logic [1:0]                                 m_rresp,
  input  logic                                       m_rlast
);
  localparam int N = OPT_NUMBER_OF_HOSTS;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam logic [IW:0] NL = N[IW:0];
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_grant, w_pick, w_off;
  logic [IW:0] w_sum;
  logic [N-1:0] w_rot;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0] r_len;
  logic w_any, w_done;
  // Rotate requests so bit 0 is the host at r_ptr; lowest set bit is the winner
  always_comb begin
    w_rot = N'({host_arvalid, host_arvalid} >> r_ptr);
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) w_off = w_rot[i] ? IW'(i) : w_off;
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    w_pick = w_sum >= NL ? IW'(w_sum - NL) : IW'(w_sum);
  end
  assign w_any = |host_arvalid;
  assign w_done = m_rvalid & m_rready & m_rlast;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_any ? ADDR : IDLE;
      ADDR: w_next = m_arready ? DATA : ADDR;
      default: w_next = w_done ? IDLE : DATA;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_grant <= '0;
      r_addr <= '0;
      r_len <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_grant <= w_pick;
        r_addr <= host_araddr[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
        r_len <= host_arlen[w_pick*8 +: 8];
      end
      if (r_state == DATA && w_done) r_ptr <= r_grant == IW'(N - 1) ? '0 : r_grant + 1'b1;
    end
  end
  assign host_arready = (r_state == IDLE && w_any) ? N'(1) << w_pick : '0;
  assign m_arvalid = r_state == ADDR;
  assign m_araddr = r_addr;
  assign m_arlen = r_len;
  assign host_rvalid = (r_state == DATA && m_rvalid) ? N'(1) << r_grant : '0;
  assign m_rready = r_state == DATA && host_rready[r_grant];
  assign host_rdata = m_rdata;
  assign host_rresp = m_rresp;
  assign host_rlast = m_rlast;
endmodule

// File: tb/tb_armleosoc_axi_read_arbiter.sv
// tb_armleosoc_axi_read_arbiter: directed vectors on a 2-host and a 4-host arbiter
module tb_armleosoc_axi_read_arbiter;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int total = 0, bad = 0;

  logic [1:0] h2_arvalid, h2_arready, h2_rvalid, h2_rready, h2_rresp;
  logic [67:0] h2_araddr;
  logic [15:0] h2_arlen;
  logic [31:0] h2_rdata, m2_rdata;
  logic h2_rlast, m2_arvalid, m2_arready, m2_rvalid, m2_rready, m2_rlast;
  logic [33:0] m2_araddr;
  logic [7:0] m2_arlen;
  logic [1:0] m2_rresp;

  logic [3:0] h4_arvalid, h4_arready, h4_rvalid, h4_rready;
  logic [135:0] h4_araddr;
  logic [31:0] h4_arlen, h4_rdata, m4_rdata;
  logic [1:0] h4_rresp, m4_rresp;
  logic h4_rlast, m4_arvalid, m4_arready, m4_rvalid, m4_rready, m4_rlast;
  logic [33:0] m4_araddr;
  logic [7:0] m4_arlen;

  armleosoc_axi_read_arbiter #(.OPT_NUMBER_OF_HOSTS(2)) dut2 (
    .clk(clk), .rst(rst), .host_arvalid(h2_arvalid), .host_arready(h2_arready),
    .host_araddr(h2_araddr), .host_arlen(h2_arlen), .host_rvalid(h2_rvalid),
    .host_rready(h2_rready), .host_rdata(h2_rdata), .host_rresp(h2_rresp),
    .host_rlast(h2_rlast), .m_arvalid(m2_arvalid), .m_arready(m2_arready),
    .m_araddr(m2_araddr), .m_arlen(m2_arlen), .m_rvalid(m2_rvalid),
    .m_rready(m2_rready), .m_rdata(m2_rdata), .m_rresp(m2_rresp), .m_rlast(m2_rlast));

  armleosoc_axi_read_arbiter #(.OPT_NUMBER_OF_HOSTS(4)) dut4 (
    .clk(clk), .rst(rst), .host_arvalid(h4_arvalid), .host_arready(h4_arready),
    .host_araddr(h4_araddr), .host_arlen(h4_arlen), .host_rvalid(h4_rvalid),
    .host_rready(h4_rready), .host_rdata(h4_rdata), .host_rresp(h4_rresp),
    .host_rlast(h4_rlast), .m_arvalid(m4_arvalid), .m_arready(m4_arready),
    .m_araddr(m4_araddr), .m_arlen(m4_arlen), .m_rvalid(m4_rvalid),
    .m_rready(m4_rready), .m_rdata(m4_rdata), .m_rresp(m4_rresp), .m_rlast(m4_rlast));

  typedef struct {
    logic [3:0] av;
    logic [3:0] er;
    logic [33:0] ea;
    logic [7:0] el;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tx4(input logic [3:0] av, input logic [3:0] er, input logic [33:0] ea,
                     input logic [7:0] el, input string nm);
    h4_arvalid = av;
    #1 chk({nm, " arready"}, 64'(h4_arready), 64'(er));
    @(posedge clk); @(negedge clk);
    h4_arvalid = '0;
    #1 chk({nm, " m_arvalid"}, 64'(m4_arvalid), 64'd1);
    chk({nm, " araddr"}, 64'(m4_araddr), 64'(ea));
    chk({nm, " arlen"}, 64'(m4_arlen), 64'(el));
    m4_arready = 1;
    @(posedge clk); @(negedge clk);
    m4_arready = 0; m4_rvalid = 1; m4_rlast = 1; h4_rready = 4'hf;
    #1 chk({nm, " rvalid"}, 64'(h4_rvalid), 64'(er));
    @(posedge clk); @(negedge clk);
    m4_rvalid = 0; m4_rlast = 0;
    #1 chk({nm, " idle"}, 64'(m4_arvalid), 64'd0);
  endtask

  task automatic run2(input logic [1:0] er, input string nm);
    #1 chk({nm, " arready"}, 64'(h2_arready), 64'(er));
    @(posedge clk); @(negedge clk);
    #1 chk({nm, " araddr"}, 64'(m2_araddr), er == 2'b01 ? 64'h100 : 64'h200);
    chk({nm, " arready in addr"}, 64'(h2_arready), 64'd0);
    m2_arready = 1;
    @(posedge clk); @(negedge clk);
    m2_arready = 0; m2_rvalid = 1; m2_rlast = 1; h2_rready = 2'b11;
    #1 chk({nm, " rvalid"}, 64'(h2_rvalid), 64'(er));
    @(posedge clk); @(negedge clk);
    m2_rvalid = 0; m2_rlast = 0;
  endtask

  initial begin
    vecs[0] = '{4'b0001, 4'b0001, 34'h1000, 8'd1};
    vecs[1] = '{4'b0001, 4'b0001, 34'h1000, 8'd1};
    vecs[2] = '{4'b0110, 4'b0010, 34'h1010, 8'd2};
    vecs[3] = '{4'b0110, 4'b0100, 34'h1020, 8'd3};
    vecs[4] = '{4'b1001, 4'b1000, 34'h1030, 8'd4};
    vecs[5] = '{4'b1001, 4'b0001, 34'h1000, 8'd1};
    vecs[6] = '{4'b1111, 4'b0010, 34'h1010, 8'd2};
    vecs[7] = '{4'b1011, 4'b1000, 34'h1030, 8'd4};
    vecs[8] = '{4'b0100, 4'b0100, 34'h1020, 8'd3};
    vecs[9] = '{4'b0011, 4'b0001, 34'h1000, 8'd1};
    h2_arvalid = 0; h2_rready = 0; h2_araddr = {34'h200, 34'h100}; h2_arlen = {8'd1, 8'd3};
    m2_arready = 0; m2_rvalid = 1; m2_rdata = 0; m2_rresp = 0; m2_rlast = 0;
    h4_arvalid = 0; h4_rready = 0;
    h4_araddr = {34'h1030, 34'h1020, 34'h1010, 34'h1000}; h4_arlen = {8'd4, 8'd3, 8'd2, 8'd1};
    m4_arready = 0; m4_rvalid = 1; m4_rdata = 0; m4_rresp = 0; m4_rlast = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 0;
    #1 chk("reset arready", 64'(h2_arready), 64'd0);
    chk("reset m_arvalid", 64'(m2_arvalid), 64'd0);
    chk("reset araddr", 64'(m2_araddr), 64'd0);
    chk("reset rvalid ignored", 64'(h2_rvalid), 64'd0);
    chk("reset m_rready", 64'(m2_rready), 64'd0);
    m2_rvalid = 0; m4_rvalid = 0;
    // single host0 burst of 4 beats
    @(negedge clk);
    h2_arvalid = 2'b01;
    #1 chk("b1 arready c0", 64'(h2_arready), 64'd1);
    @(posedge clk); @(negedge clk);
    h2_arvalid = 0; m2_rvalid = 1; h2_rready = 2'b11;
    #1 chk("b1 m_arvalid c1", 64'(m2_arvalid), 64'd1);
    chk("b1 araddr", 64'(m2_araddr), 64'h100);
    chk("b1 arlen", 64'(m2_arlen), 64'd3);
    chk("b1 rvalid ignored in addr", 64'(h2_rvalid), 64'd0);
    chk("b1 m_rready in addr", 64'(m2_rready), 64'd0);
    m2_arready = 1;
    @(posedge clk); @(negedge clk);
    m2_arready = 0;
    for (int b = 0; b < 4; b++) begin
      m2_rvalid = 1; m2_rdata = 32'hA0 + b; m2_rlast = b == 3;
      #1 chk("b1 rvalid", 64'(h2_rvalid), 64'd1);
      chk("b1 rdata", 64'(h2_rdata), 64'hA0 + b);
      chk("b1 m_rready", 64'(m2_rready), 64'd1);
      @(posedge clk); @(negedge clk);
    end
    m2_rvalid = 0; m2_rlast = 0;
    #1 chk("b1 back idle", 64'(m2_arvalid), 64'd0);
    chk("b1 idle rvalid", 64'(h2_rvalid), 64'd0);
    // both request, ptr=1 so host1 wins; device stalls AR for 5 cycles
    h2_arvalid = 2'b11;
    #1 chk("stall arready c0", 64'(h2_arready), 64'd2);
    @(posedge clk); @(negedge clk);
    h2_arvalid = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #1 chk("stall m_arvalid", 64'(m2_arvalid), 64'd1);
      chk("stall araddr", 64'(m2_araddr), 64'h200);
      chk("stall arlen", 64'(m2_arlen), 64'd1);
      chk("stall no arready", 64'(h2_arready), 64'd0);
      @(posedge clk); @(negedge clk);
    end
    m2_arready = 1;
    @(posedge clk); @(negedge clk);
    m2_arready = 0;
    // host1 stalls rready 3 cycles between two beats; SLVERR on last beat
    for (int c = 0; c < 5; c++) begin
      m2_rvalid = 1;
      h2_rready = (c == 0 || c == 4) ? 2'b10 : 2'b01;
      m2_rdata = c == 0 ? 32'h11 : 32'h22;
      m2_rlast = c != 0; m2_rresp = c == 4 ? 2'b10 : 2'b00;
      #1 chk("rstall m_rready", 64'(m2_rready), (c == 0 || c == 4) ? 64'd1 : 64'd0);
      chk("rstall rvalid", 64'(h2_rvalid), 64'd2);
      chk("rstall rdata", 64'(h2_rdata), c == 0 ? 64'h11 : 64'h22);
      chk("rstall no arready", 64'(h2_arready), 64'd0);
      if (c == 4) begin
        chk("rstall rresp", 64'(h2_rresp), 64'd2);
        chk("rstall rlast", 64'(h2_rlast), 64'd1);
      end
      @(posedge clk); @(negedge clk);
    end
    m2_rvalid = 0; m2_rlast = 0; m2_rresp = 0;
    // continuous requests alternate starting at host0
    h2_arvalid = 2'b11;
    run2(2'b01, "rr0");
    run2(2'b10, "rr1");
    run2(2'b01, "rr2");
    run2(2'b10, "rr3");
    h2_arvalid = 0;
    // 4-host round-robin table
    for (int i = 0; i < 10; i++)
      tx4(vecs[i].av, vecs[i].er, vecs[i].ea, vecs[i].el, $sformatf("vec%0d", i));
    // reset during DATA aborts the transaction and clears ptr
    h4_arvalid = 4'b0010;
    #1 chk("rd arready", 64'(h4_arready), 64'd2);
    @(posedge clk); @(negedge clk);
    h4_arvalid = 0; m4_arready = 1;
    @(posedge clk); @(negedge clk);
    m4_arready = 0; m4_rvalid = 1; h4_rready = 4'hf;
    #1 chk("rd in data", 64'(h4_rvalid), 64'd2);
    rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0;
    #1 chk("rd rvalid", 64'(h4_rvalid), 64'd0);
    chk("rd m_rready", 64'(m4_rready), 64'd0);
    chk("rd m_arvalid", 64'(m4_arvalid), 64'd0);
    chk("rd araddr", 64'(m4_araddr), 64'd0);
    chk("rd arlen", 64'(m4_arlen), 64'd0);
    chk("rd arready", 64'(h4_arready), 64'd0);
    m4_rvalid = 0;
    tx4(4'b0101, 4'b0001, 34'h1000, 8'd1, "rd ptr0");
    tx4(4'b0100, 4'b0100, 34'h1020, 8'd3, "rd host2");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/armleosoc_axi_read_arbiter.md
ARMLEOSOC_AXI_READ_ARBITER -- requirements
Module: armleosoc_axi_read_arbiter

Interface
REQ-001 SHALL have parameter OPT_NUMBER_OF_HOSTS, default 2, number of read hosts N (N>=1).
REQ-002 SHALL have parameter ADDR_WIDTH, default 34, AXI4 address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, AXI4 read data width.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 host_arvalid  input  N  per-host AR valid.
REQ-007 host_arready  output  N  per-host AR ready, at most one bit set.
REQ-008 host_araddr  input  N*ADDR_WIDTH  per-host address, host i at slice i.
REQ-009 host_arlen  input  N*8  per-host burst length minus one.
REQ-010 host_rvalid  output  N  per-host R valid, at most one bit set.
REQ-011 host_rready  input  N  per-host R ready.
REQ-012 host_rdata  output  DATA_WIDTH  R data broadcast to all hosts.
REQ-013 host_rresp  output  2  R response broadcast.
REQ-014 host_rlast  output  1  R last broadcast.
REQ-015 m_arvalid / m_arready  output / input  1 / 1  device AR handshake.
REQ-016 m_araddr / m_arlen  output  ADDR_WIDTH / 8  device AR payload.
REQ-017 m_rvalid / m_rready  input / output  1 / 1  device R handshake.
REQ-018 m_rdata / m_rresp / m_rlast  input  DATA_WIDTH / 2 / 1  device R payload.

Function
REQ-019 SHALL implement states IDLE, ADDR, DATA; one transaction in flight at a time.
REQ-020 IDLE: if any host_arvalid, SHALL pick grant g round-robin, starting search at index ptr, wrapping N-1 -> 0.
REQ-021 IDLE: SHALL assert host_arready[g] combinationally in the same cycle as the pick; capture host_araddr[g], host_arlen[g], g into registers; go to ADDR.
REQ-022 IDLE with no host_arvalid: all host_arready low, stay IDLE.
REQ-023 ADDR: m_arvalid=1 from registered payload (no combinational path host->m_ar*); payload stable until m_arready; on m_arready go to DATA.
REQ-024 DATA: host_rvalid[g]=m_rvalid, m_rready=host_rready[g]; other host_rvalid bits 0; rdata/rresp/rlast passed combinationally.
REQ-025 DATA: on m_rvalid & m_rready & m_rlast SHALL set ptr=(g+1) mod N and return to IDLE; earliest re-grant next cycle.
REQ-026 m_rvalid in IDLE/ADDR SHALL be ignored; m_rready=0 outside DATA.
REQ-027 Any m_rresp value (incl. SLVERR/DECERR) SHALL be forwarded unchanged; no retry.
REQ-028 Beat count not checked; only m_rlast ends DATA.
REQ-029 Hosts not granted SHALL see arready=0 and may hold arvalid indefinitely (no starvation: every requester granted within N transactions).
REQ-030 Minimum latency: host AR accept cycle 0, m_arvalid cycle 1.

Reset
REQ-031 rst high at edge: state=IDLE, ptr=0, m_arvalid=0, registered payload=0; host_arready, host_rvalid, m_rready=0 while in IDLE after reset.
REQ-032 Reset mid-ADDR or mid-DATA SHALL abort transaction immediately; no outputs held afterwards.

Verification
REQ-033 N=2, host0 single request arlen=3 addr=0x100 -> accepted cycle 0, m_arvalid cycle 1 with 0x100/3, 4 beats to host0 only, IDLE after rlast.
REQ-034 Host0 and host1 request continuously, ptr=0 -> grant order 0,1,0,1.
REQ-035 m_arready held low 5 cycles -> m_arvalid and payload stable 5 cycles, no host_arready during that time.
REQ-036 Host stalls rready 3 cycles mid-burst -> m_rready low same cycles, no beat lost; rresp=2'b10 on last beat forwarded.
REQ-037 N=4, rst asserted in DATA -> next cycle IDLE, ptr=0, all outputs 0; new request from host2 granted.
